ber_sync_ctrl: RTL and testbench

- Sequencer for the BER counter datapath.
- After enable, it issues a one-cycle clear to the counter, then sweeps every candidate latency in synchronization mode. For each candidate it compares a fixed window of bits, then pulses address-done.
- Once the sweep completes, it switches the counter to BER counting mode.
- It sits between the top-level control (switches/VIO) and the BER counter, and runs at the BR strobe rate.

---
 rtl/ber_sync_ctrl.sv | 69 ++++++
 tb/tb_ber_sync_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ber_sync_ctrl.sv
// ber_sync_ctrl: BER counter sequencer that clears the counter, sweeps candidate latencies
// in synchronization mode, then switches the counter to BER counting mode.
module ber_sync_ctrl #(
  parameter int PRBS_MAX_CYCLES = 511,
  parameter int SYNC_WINDOW     = 511,
  localparam int IDX_BITS = $clog2(PRBS_MAX_CYCLES)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_ctrl,
  input  logic                i_enable,
  input  logic                i_resync,
  output logic                o_ber_reset,
  output logic                o_synchro_en,
  output logic                o_prbs_cmp_curr_addr_done,
  output logic                o_ber_counter_en,
  output logic                o_sync_done,
  output logic [IDX_BITS-1:0] o_cand_idx,
  output logic [1:0]          o_state,
  output logic [7:0]          o_sync_count
);
  localparam int BIT_BITS = $clog2(SYNC_WINDOW + 1);
  localparam logic [BIT_BITS-1:0] WIN  = BIT_BITS'(SYNC_WINDOW);
  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(PRBS_MAX_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, CLR, SYNC, COUNT} state_t;
  state_t              r_state, w_next;
  logic [BIT_BITS-1:0] r_bit_cnt;
  logic [IDX_BITS-1:0] r_cand_cnt;
  logic [7:0]          r_sync_count;
  logic                w_win_end, w_last_cand;
  assign w_win_end   = r_bit_cnt == WIN;
  assign w_last_cand = r_cand_cnt == LAST;
  always_comb begin
    w_next = r_state;
    if (!i_enable) w_next = IDLE;
    else if (i_resync && (r_state == SYNC || r_state == COUNT)) w_next = CLR;
    else if (r_state == IDLE) w_next = CLR;
    else if (r_state == CLR) w_next = SYNC;
    else if (r_state == SYNC && i_ctrl && w_win_end && w_last_cand) w_next = COUNT;
  end
  // counters are held at zero whenever the sequencer is not continuing a sweep
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_cand_cnt   <= '0;
      r_sync_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != SYNC) begin
        r_bit_cnt  <= '0;
        r_cand_cnt <= '0;
      end else if (r_state == SYNC && i_ctrl) begin
        r_bit_cnt  <= w_win_end ? '0 : r_bit_cnt + 1'b1;
        r_cand_cnt <= w_win_end ? r_cand_cnt + 1'b1 : r_cand_cnt;
      end
      if (r_state == SYNC && w_next == COUNT && r_sync_count != 8'hff)
        r_sync_count <= r_sync_count + 1'b1;
    end
  end
  assign o_ber_reset               = r_state == CLR;
  assign o_synchro_en              = r_state == SYNC;
  assign o_prbs_cmp_curr_addr_done = r_state == SYNC && w_win_end;
  assign o_ber_counter_en          = r_state == COUNT;
  assign o_sync_done               = r_state == COUNT;
  assign o_cand_idx                = r_cand_cnt;
  assign o_state                   = r_state;
  assign o_sync_count              = r_sync_count;
endmodule

// File: tb/tb_ber_sync_ctrl.sv
// tb_ber_sync_ctrl: randomized bench for ber_sync_ctrl against a strobe-count sweep model.
module tb_ber_sync_ctrl;
  localparam int MAXC = 7;
  localparam int W    = 4;
  localparam int N    = MAXC * (W + 1);
  logic       clk = 0, i_rst_n, i_ctrl = 0, i_enable, i_resync;
  logic       o_ber_reset, o_synchro_en, o_done, o_ber_counter_en, o_sync_done;
  logic [2:0] o_cand_idx;
  logic [1:0] o_state;
  logic [7:0] o_sync_count;
  int tests = 0, fails = 0, mode = 0, cyc = 0, strobes = 0, sc0 = 0;
  int m_state = 0, m_n = 0, m_cnt = 0;
  ber_sync_ctrl #(.PRBS_MAX_CYCLES(MAXC), .SYNC_WINDOW(W)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_ctrl(i_ctrl), .i_enable(i_enable), .i_resync(i_resync),
    .o_ber_reset(o_ber_reset), .o_synchro_en(o_synchro_en), .o_prbs_cmp_curr_addr_done(o_done),
    .o_ber_counter_en(o_ber_counter_en), .o_sync_done(o_sync_done), .o_cand_idx(o_cand_idx),
    .o_state(o_state), .o_sync_count(o_sync_count));
  always #5 clk = ~clk;
  // strobe generator: every 4th clk, random, or held low
  always @(negedge clk) begin
    cyc++;
    i_ctrl = mode == 0 ? (cyc % 4 == 0) : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(posedge clk) if (i_ctrl && o_state == 2) strobes++;
  // model: a sweep is N strobes; candidate and window position follow from the strobe count
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_state = 0; m_n = 0; m_cnt = 0;
    end else if (!i_enable) begin
      m_state = 0; m_n = 0;
    end else if (i_resync && m_state >= 2) begin
      m_state = 1; m_n = 0;
    end else if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      m_state = 2; m_n = 0;
    end else if (m_state == 2 && i_ctrl) begin
      if (m_n == N - 1) begin
        m_state = 3; m_n = 0; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
      end else m_n++;
    end
  end
  always @(negedge clk) begin
    logic [15:0] act, exp;
    act = {o_ber_reset, o_synchro_en, o_done, o_ber_counter_en, o_sync_done, o_cand_idx, o_state, o_sync_count[4:0]};
    exp = {m_state == 1, m_state == 2, m_state == 2 && m_n % (W + 1) == W, m_state == 3, m_state == 3,
           3'(m_state == 2 ? m_n / (W + 1) : 0), 2'(m_state), 5'(m_cnt)};
    tests += 2;
    if (act !== exp || o_sync_count !== 8'(m_cnt)) begin
      fails++;
      $display("FAIL model t=%0t: got %h cnt %0d expected %h cnt %0d", $time, act, o_sync_count, exp, m_cnt);
    end
    if (o_synchro_en && o_ber_counter_en) begin
      fails++;
      $display("FAIL mutex t=%0t: got both enables 1 expected at most one", $time);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int field(input int f);
    return f == 0 ? int'(o_state) : f == 1 ? int'(o_done) : int'(o_cand_idx);
  endfunction
  task automatic wait_for(input string nm, input int f, input int v, input int lim);
    int k = 0;
    while (field(f) != v && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, field(f), v);
  endtask
  task automatic pulse_resync;
    i_resync = 1;
    @(negedge clk);
    i_resync = 0;
  endtask
  initial begin
    i_rst_n = 0; i_enable = 0; i_resync = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", o_state, 0);
    chk("reset_count", o_sync_count, 0);
    i_rst_n = 1;
    @(negedge clk);
    i_enable = 1;
    @(negedge clk);
    chk("clr_state", o_state, 1);
    chk("clr_pulse", o_ber_reset, 1);
    @(negedge clk);
    chk("sync_state", o_state, 2);
    chk("sync_cand0", o_cand_idx, 0);
    chk("sync_no_reset", o_ber_reset, 0);
    sc0 = strobes;
    wait_for("done1", 1, 1, 100);
    chk("done_after_4", strobes - sc0, 4);
    wait_for("cand1", 2, 1, 100);
    chk("drop_after_5", strobes - sc0, 5);
    chk("done_dropped", o_done, 0);
    wait_for("count1", 0, 3, 500);
    chk("sweep_35", strobes - sc0, N);
    chk("sync_done", o_sync_done, 1);
    chk("count_1", o_sync_count, 1);
    chk("synchro_off", o_synchro_en, 0);
    pulse_resync();
    chk("resync_clr", o_state, 1);
    wait_for("done_hold", 1, 1, 100);
    mode = 2;
    repeat (100) @(negedge clk);
    chk("hold_done", o_done, 1);
    chk("hold_state", o_state, 2);
    chk("hold_cand", o_cand_idx, 0);
    mode = 0;
    wait_for("cand3", 2, 3, 300);
    pulse_resync();
    chk("mid_resync_clr", o_state, 1);
    @(negedge clk);
    chk("mid_resync_cand", o_cand_idx, 0);
    chk("mid_resync_cnt", o_sync_count, 1);
    wait_for("count2", 0, 3, 500);
    chk("count_2", o_sync_count, 2);
    i_enable = 0; i_resync = 1;
    @(negedge clk);
    i_resync = 0;
    chk("disable_idle", o_state, 0);
    chk("disable_en", o_ber_counter_en, 0);
    i_enable = 1;
    wait_for("sync_again", 0, 2, 20);
    repeat (7) @(negedge clk);
    chk("pre_async", o_synchro_en, 1);
    @(posedge clk);
    #2 i_rst_n = 0;
    #1 chk("async_state", o_state, 0);
    chk("async_synchro", o_synchro_en, 0);
    chk("async_cnt", o_sync_count, 0);
    @(negedge clk);
    i_rst_n = 1;
    mode = 1;
    for (int i = 0; i < 256; i++) begin
      wait_for("sweep_loop", 0, 3, 2000);
      pulse_resync();
    end
    chk("saturate_255", o_sync_count, 255);
    for (int i = 0; i < 600; i++) begin
      i_enable = $urandom_range(0, 19) != 0;
      i_resync = $urandom_range(0, 29) == 0;
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
